// File: rtl/srff_cmd_arbiter_pkg.sv
// Shared types for the SR flip-flop command arbiter: FSM state encoding and op codes.
// Latency: none (declarations only); backpressure: n/a.
package srff_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/srff_cmd_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from ptr, wrapping modulo NREQ.
// Latency: combinational; backpressure: none, valid simply reflects |req.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  id
);

    int idx;

    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!valid && req[idx[IDW-1:0]]) begin
                valid = 1'b1;
                id    = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/srff_cmd_arbiter.sv
// Arbitrates SET/RESET commands from NREQ requesters onto one shared SR flip-flop and verifies q.
// Latency: 3 cycles per command (IDLE->ISSUE->CHECK); backpressure: req held until its gnt pulse.
module srff_cmd_arbiter
    import srff_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    input  logic            err_clr,
    input  logic            q_in,
    output logic            s,
    output logic            r,
    output logic [NREQ-1:0] gnt,
    output logic            done,
    output logic [IDW-1:0]  last_id,
    output logic            busy,
    output logic            err
);

    state_t            state_q, state_d;
    logic [IDW-1:0]    id_q, id_d;
    logic              op_q, op_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              s_q, s_d;
    logic              r_q, r_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              done_q, done_d;
    logic [IDW-1:0]    last_id_q, last_id_d;
    logic              err_q, err_d;

    logic              pick_vld;
    logic [IDW-1:0]    pick_id;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_vld),
        .id    (pick_id)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        op_d      = op_q;
        ptr_d     = ptr_q;
        s_d       = 1'b0;
        r_d       = 1'b0;
        gnt_d     = '0;
        done_d    = 1'b0;
        last_id_d = last_id_q;
        err_d     = err_q;

        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    id_d    = pick_id;
                    op_d    = op[pick_id];
                    gnt_d   = NREQ'(1) << pick_id;
                    // s and r are complementary by construction, so never both high
                    s_d     = (op[pick_id] == OP_SET);
                    r_d     = (op[pick_id] == OP_RESET);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                done_d    = 1'b1;
                last_id_d = id_q;
                ptr_d     = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                // a mismatch overrides a coincident err_clr
                if (q_in != op_q) begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            op_q      <= 1'b0;
            ptr_q     <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            last_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            op_q      <= op_d;
            ptr_q     <= ptr_d;
            s_q       <= s_d;
            r_q       <= r_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            last_id_q <= last_id_d;
            err_q     <= err_d;
        end
    end

    assign s       = s_q;
    assign r       = r_q;
    assign gnt     = gnt_q;
    assign done    = done_q;
    assign last_id = last_id_q;
    assign err     = err_q;
    assign busy    = (state_q != ST_IDLE);

endmodule
